// File: rtl/request_arbiter_pkg.sv
// Shared constants and types for the round-robin request arbiter.
package request_arbiter_pkg;

  localparam int NUM_REQ          = 16;
  localparam int ID_W             = 4;
  localparam int DEFAULT_MAX_HOLD = 15;
  localparam int HOLD_W           = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/request_arbiter_rr_priority_select.sv
// Round-robin winner selection: lowest set request at or above ptr,
// otherwise the lowest set request overall (wrap-around).
module rr_priority_select
  import request_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] masked;
  logic [ID_W-1:0]    masked_idx;
  logic [ID_W-1:0]    raw_idx;

  // Two priority encodes; scanning downward lets the lowest index win.
  always_comb begin
    mask       = {NUM_REQ{1'b1}} << ptr;
    masked     = req & mask;
    masked_idx = '0;
    raw_idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (masked[i]) masked_idx = ID_W'(i);
      if (req[i])    raw_idx    = ID_W'(i);
    end
    any_valid = |req;
    winner    = (|masked) ? masked_idx : raw_idx;
  end

endmodule

// File: rtl/request_arbiter.sv
// Round-robin arbiter with a bounded grant duration.
// Handshake: a requester holds req[i] high until served; the grant is
// presented on gnt/gnt_id with gnt_valid=1 one cycle after arbitration.
// The holder ends the grant by pulsing done (only meaningful while
// gnt_valid=1) or by dropping its req bit; a grant reaching max_hold
// cycles is revoked and timeout pulses for the following cycle.
// Every grant is followed by exactly one idle cycle.
module request_arbiter #(
  parameter int NUM_REQ  = request_arbiter_pkg::NUM_REQ,
  parameter int MAX_HOLD = request_arbiter_pkg::DEFAULT_MAX_HOLD
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic                                 done,
  output logic [NUM_REQ-1:0]                   gnt,
  output logic [request_arbiter_pkg::ID_W-1:0] gnt_id,
  output logic                                 gnt_valid,
  output logic                                 timeout,
  output request_arbiter_pkg::arb_state_e      state
);

  import request_arbiter_pkg::*;

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   win_id;
  logic              win_valid;
  logic [HOLD_W-1:0] hold_cnt;
  logic              holder_req;
  logic              hold_hit;

  rr_priority_select u_sel (
    .req       (req),
    .ptr       (ptr),
    .winner    (win_id),
    .any_valid (win_valid)
  );

  assign holder_req = req[gnt_id];
  assign hold_hit   = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  // Arbitration FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            state     <= GRANT;
            gnt       <= NUM_REQ'(1) << win_id;
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            ptr       <= win_id + 1'b1;
          end
        end
        GRANT: begin
          if (hold_cnt != {HOLD_W{1'b1}}) hold_cnt <= hold_cnt + 1'b1;
          if (done || !holder_req || hold_hit) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            // Only a pure hold-limit revocation is reported as a timeout.
            timeout   <= !done && holder_req;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_request_arbiter.sv
// Bench for request_arbiter: behavioural model plus directed sequences.
module tb_request_arbiter;
  import request_arbiter_pkg::*;

  localparam int HOLD = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        done;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  gnt_id;
  logic        gnt_valid;
  logic        timeout;
  arb_state_e  state_dbg;

  always #5 clk = ~clk;

  request_arbiter #(.NUM_REQ(16), .MAX_HOLD(HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout),
    .state     (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_fail = 0;
  int         to_cnt = 0;
  logic       prev_valid = 1'b0;
  logic [3:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks who holds the resource, for how long, and where the search starts.
  logic m_live = 1'b0;
  logic m_busy = 1'b0;
  logic m_to   = 1'b0;
  int   m_id   = 0;
  int   m_ptr  = 0;
  int   m_hold = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_live = 1'b1;
      m_busy = 1'b0;
      m_to   = 1'b0;
      m_id   = 0;
      m_ptr  = 0;
      m_hold = 0;
    end else begin
      m_to = 1'b0;
      if (m_busy) begin
        if (done || !req[m_id] || m_hold == HOLD - 1) begin
          m_to   = !done && req[m_id];
          m_busy = 1'b0;
          m_id   = 0;
        end else begin
          m_hold = (m_hold < 255) ? m_hold + 1 : 255;
        end
      end else begin
        for (int k = 0; k < 16; k++) begin
          if (!m_busy && req[(m_ptr + k) % 16]) begin
            m_id   = (m_ptr + k) % 16;
            m_busy = 1'b1;
          end
        end
        if (m_busy) begin
          m_hold = 0;
          m_ptr  = (m_id + 1) % 16;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk("gnt",       {16'd0, gnt},       m_busy ? (32'd1 << m_id) : 32'd0);
        chk("gnt_id",    {28'd0, gnt_id},    m_busy ? 32'(m_id) : 32'd0);
        chk("gnt_valid", {31'd0, gnt_valid}, {31'd0, m_busy});
        chk("timeout",   {31'd0, timeout},   {31'd0, m_to});
        chk("state",     {31'd0, state_dbg == GRANT}, {31'd0, m_busy});
        chk("onehot",    {31'd0, $countones(gnt) <= 1}, 32'd1);
        if (timeout === 1'b1) to_cnt++;
        if (gnt_valid === 1'b1 && !prev_valid && exp_q.size() > 0)
          chk("grant_seq", {28'd0, gnt_id}, {28'd0, exp_q.pop_front()});
        prev_valid = (gnt_valid === 1'b1);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic [15:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int to_base;
    reset = 1'b0;
    req   = '0;
    done  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_gnt",   {16'd0, gnt},       32'd0);
    chk("rst_id",    {28'd0, gnt_id},    32'd0);
    chk("rst_valid", {31'd0, gnt_valid}, 32'd0);
    chk("rst_to",    {31'd0, timeout},   32'd0);
    reset = 1'b1;

    // Idle with no requests.
    repeat (5) cyc(16'h0000, 1'b0);
    chk("idle_valid", {31'd0, gnt_valid}, 32'd0);

    // Two requesters alternate: 0, 15, 0, 15.
    exp_q = {4'd0, 4'd15, 4'd0, 4'd15};
    cyc(16'h8001, 1'b0);
    chk("rr_first", {16'd0, gnt}, 32'h0001);
    repeat (3) begin
      cyc(16'h8001, 1'b0);
      cyc(16'h8001, 1'b1);
      cyc(16'h8001, 1'b0);
    end
    cyc(16'h8001, 1'b0);
    cyc(16'h8001, 1'b1);
    cyc(16'h0000, 1'b0);
    chk("rr_drain", 32'(exp_q.size()), 32'd0);

    // Grant 14 moves the pointer to 15; next search wraps to 0, then 1.
    exp_q = {4'd14, 4'd0, 4'd1};
    cyc(16'h4000, 1'b0);
    cyc(16'h4000, 1'b1);
    cyc(16'h0003, 1'b0);
    chk("wrap_id", {28'd0, gnt_id}, 32'd0);
    cyc(16'h0003, 1'b1);
    cyc(16'h0003, 1'b0);
    chk("wrap_next", {28'd0, gnt_id}, 32'd1);
    cyc(16'h0003, 1'b1);
    cyc(16'h0000, 1'b0);
    chk("wrap_drain", 32'(exp_q.size()), 32'd0);

    // Hold limit: 4 cycles of grant, then timeout in the gap, then regrant.
    exp_q   = {4'd4, 4'd4, 4'd4};
    to_base = to_cnt;
    cyc(16'h0010, 1'b0);
    chk("hold_c1", {16'd0, gnt}, 32'h0010);
    repeat (3) cyc(16'h0010, 1'b0);
    chk("hold_c4", {16'd0, gnt}, 32'h0010);
    cyc(16'h0010, 1'b0);
    chk("hold_gap_gnt", {16'd0, gnt}, 32'd0);
    chk("hold_gap_to",  {31'd0, timeout}, 32'd1);
    cyc(16'h0010, 1'b0);
    chk("hold_regrant", {16'd0, gnt}, 32'h0010);
    chk("hold_re_to",   {31'd0, timeout}, 32'd0);
    repeat (5) cyc(16'h0010, 1'b0);
    cyc(16'h0000, 1'b0);
    chk("hold_drop_to", {31'd0, timeout}, 32'd0);
    cyc(16'h0000, 1'b0);
    chk("hold_to_count", 32'(to_cnt - to_base), 32'd2);
    chk("hold_drain", 32'(exp_q.size()), 32'd0);

    // Requester 3 drops its request; done in idle is ignored.
    exp_q = {4'd3};
    cyc(16'h0008, 1'b0);
    chk("drop_id", {28'd0, gnt_id}, 32'd3);
    cyc(16'h0000, 1'b0);
    chk("drop_gnt", {16'd0, gnt}, 32'd0);
    chk("drop_to",  {31'd0, timeout}, 32'd0);
    cyc(16'h0000, 1'b1);
    cyc(16'h0000, 1'b1);
    chk("idle_done", {31'd0, gnt_valid}, 32'd0);

    // Reset during a grant, then all-request arbitration starts at 0.
    exp_q = {4'd6, 4'd0, 4'd1};
    cyc(16'h0040, 1'b0);
    chk("pre_rst_id", {28'd0, gnt_id}, 32'd6);
    reset = 1'b0;
    cyc(16'h0040, 1'b0);
    chk("mid_rst_gnt",   {16'd0, gnt},       32'd0);
    chk("mid_rst_valid", {31'd0, gnt_valid}, 32'd0);
    chk("mid_rst_to",    {31'd0, timeout},   32'd0);
    reset = 1'b1;
    cyc(16'hFFFF, 1'b0);
    chk("post_rst_gnt", {16'd0, gnt}, 32'h0001);
    cyc(16'hFFFF, 1'b1);
    cyc(16'hFFFF, 1'b0);
    chk("post_rst_next", {16'd0, gnt}, 32'h0002);
    cyc(16'hFFFF, 1'b1);
    cyc(16'h0000, 1'b0);
    chk("rst_drain", 32'(exp_q.size()), 32'd0);

    // Mixed traffic, checked by the model every cycle.
    repeat (300) begin
      cyc(16'($urandom_range(0, 65535)) & 16'($urandom_range(0, 65535)),
          ($urandom_range(0, 3) == 0));
    end
    repeat (3) cyc(16'h0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
